// File: rtl/remote_cmd_arbiter_if.sv
// remote_cmd_arbiter_if: requester and RemoteComm signals of the command arbiter
interface remote_cmd_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]    req;
  logic [NREQ*8-1:0]  req_cmd;
  logic [NREQ*16-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [7:0]         done_resp;
  logic               done_tmo;
  logic               busy;
  logic               send_cmd;
  logic [7:0]         cmd;
  logic [15:0]        data;
  logic               cmd_sent;
  logic               resp_rdy;
  logic [7:0]         resp;
  logic               clr_resp_rdy;
  modport master (
    output req, req_cmd, req_data, cmd_sent, resp_rdy, resp,
    input  gnt, done, done_resp, done_tmo, busy, send_cmd, cmd, data, clr_resp_rdy
  );
  modport slave (
    input  req, req_cmd, req_data, cmd_sent, resp_rdy, resp,
    output gnt, done, done_resp, done_tmo, busy, send_cmd, cmd, data, clr_resp_rdy
  );
endinterface

// File: rtl/remote_cmd_arbiter.sv
// remote_cmd_arbiter: round-robin sharing of one RemoteComm command/response channel
module remote_cmd_arbiter #(
  parameter int NREQ        = 4,
  parameter int TIMEOUT_CYC = 2_000_000
) (
  input logic                 clk,
  input logic                 rst,
  remote_cmd_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = TIMEOUT_CYC > 1 ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [1:0] IDLE = 2'd0, SEND = 2'd1, WAIT_SENT = 2'd2, WAIT_RESP = 2'd3;
  logic [1:0]    state, nxt;
  logic [IW-1:0] last, idx, pick, j;
  logic [IW:0]   s;
  logic          found, fin;
  logic [CW-1:0] cnt;
  logic [7:0]    cmd_r;
  logic [15:0]   data_r;
  // walk downwards so the nearest requester after last overwrites the farther ones
  always_comb begin
    pick = '0;
    found = 1'b0;
    s = '0;
    j = '0;
    for (int k = NREQ; k >= 1; k--) begin
      s = {1'b0, last} + (IW+1)'(k);
      j = IW'(s >= (IW+1)'(NREQ) ? s - (IW+1)'(NREQ) : s);
      if (bus.req[j]) begin
        pick = j;
        found = 1'b1;
      end
    end
  end
  assign fin = state == WAIT_RESP && (bus.resp_rdy || cnt == TMO_LAST);
  always_comb
    nxt = state == IDLE      ? (found ? SEND : IDLE) :
          state == SEND      ? WAIT_SENT :
          state == WAIT_SENT ? (bus.cmd_sent ? WAIT_RESP : WAIT_SENT) :
          fin                ? IDLE : WAIT_RESP;
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      last   <= IW'(NREQ - 1);
      idx    <= '0;
      cnt    <= '0;
      cmd_r  <= '0;
      data_r <= '0;
    end else begin
      state <= nxt;
      cnt   <= state == WAIT_RESP ? cnt + 1'b1 : '0;
      if (state == IDLE && found) begin
        idx    <= pick;
        last   <= pick;
        cmd_r  <= bus.req_cmd[8*pick +: 8];
        data_r <= bus.req_data[16*pick +: 16];
      end
    end
  end
  // any resp_rdy is acknowledged; outside WAIT_RESP it is stale and simply dropped
  assign bus.clr_resp_rdy = bus.resp_rdy;
  assign bus.gnt          = (state == IDLE && found) ? NREQ'(1) << pick : '0;
  assign bus.done         = fin ? NREQ'(1) << idx : '0;
  assign bus.done_tmo     = fin && !bus.resp_rdy;
  assign bus.done_resp    = (state == WAIT_RESP && bus.resp_rdy) ? bus.resp : 8'h00;
  assign bus.busy         = state != IDLE;
  assign bus.send_cmd     = state == SEND;
  assign bus.cmd          = cmd_r;
  assign bus.data         = data_r;
endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// tb_remote_cmd_arbiter: directed and random transactions checked against a transaction-level model
module tb_remote_cmd_arbiter;
  localparam int NREQ = 4;
  localparam int TMO  = 100;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  bit   armed = 1'b0;
  remote_cmd_arbiter_if #(.NREQ(NREQ)) bus();
  remote_cmd_arbiter #(.NREQ(NREQ), .TIMEOUT_CYC(TMO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  function automatic void chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, a, e, $time);
    end
  endfunction

  // model: owner<0 means idle; since counts cycles after grant; wait counts response-wait cycles
  int          m_owner = -1;
  int          m_last  = NREQ - 1;
  int          m_since = 0;
  int          m_wait  = 0;
  bit          m_sent  = 1'b0;
  logic [7:0]  m_cmd   = '0;
  logic [15:0] m_data  = '0;

  always @(negedge clk) begin
    int p;
    bit fin;
    p = -1;
    for (int k = 1; k <= NREQ; k++)
      if (p < 0 && bus.req[(m_last + k) % NREQ]) p = (m_last + k) % NREQ;
    fin = m_owner >= 0 && m_sent && (bus.resp_rdy || m_wait == TMO - 1);
    if (armed) begin
      chk("gnt", 32'(bus.gnt), (m_owner < 0 && p >= 0) ? 32'(1) << p : 0);
      chk("done", 32'(bus.done), fin ? 32'(1) << m_owner : 0);
      chk("done_tmo", 32'(bus.done_tmo), 32'(fin && !bus.resp_rdy));
      chk("done_resp", 32'(bus.done_resp), (fin && bus.resp_rdy) ? 32'(bus.resp) : 0);
      chk("busy", 32'(bus.busy), 32'(m_owner >= 0));
      chk("send_cmd", 32'(bus.send_cmd), 32'(m_owner >= 0 && m_since == 1));
      chk("clr_resp_rdy", 32'(bus.clr_resp_rdy), 32'(bus.resp_rdy));
      chk("cmd", 32'(bus.cmd), 32'(m_cmd));
      chk("data", 32'(bus.data), 32'(m_data));
    end
    if (rst) begin
      m_owner = -1; m_last = NREQ - 1; m_sent = 0; m_cmd = '0; m_data = '0;
      armed = 1'b1;
    end else if (m_owner < 0) begin
      if (p >= 0) begin
        m_owner = p; m_last = p; m_since = 1; m_sent = 0;
        m_cmd = bus.req_cmd[8*p +: 8]; m_data = bus.req_data[16*p +: 16];
      end
    end else if (m_since == 1) m_since = 2;
    else if (!m_sent) begin
      if (bus.cmd_sent) begin m_sent = 1; m_wait = 0; end
    end else if (fin) m_owner = -1;
    else m_wait++;
  end

  // every task starts and ends just after a rising edge, where inputs are driven
  task automatic wait_gnt(output int who);
    who = -1;
    for (int i = 0; i < 20 && who < 0; i++) begin
      @(negedge clk);
      for (int b = 0; b < NREQ; b++) if (bus.gnt[b]) who = b;
      @(posedge clk); #1;
      bus.resp_rdy = 1'b0;
    end
    checks++;
    if (who < 0) begin
      errors++;
      $display("FAIL gnt_wait: no grant within 20 cycles at %0t", $time);
    end
  endtask

  task automatic serve(input int sdly, input bit stale, input bit give, input int rdly,
                       input logic [7:0] r, output int lat, output logic [3:0] dv,
                       output logic [7:0] dr, output logic dt, output logic dc);
    lat = -1; dv = '0; dr = '0; dt = 1'b0; dc = 1'b0;
    bus.resp_rdy = stale;
    bus.resp = 8'($urandom);
    @(negedge clk);
    chk("send_after_gnt", 32'(bus.send_cmd), 1);
    @(posedge clk); #1;
    bus.resp_rdy = 1'b0;
    repeat (sdly) begin @(negedge clk); @(posedge clk); #1; end
    bus.cmd_sent = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    bus.cmd_sent = 1'b0;
    for (int n = 1; n <= 150 && lat < 0; n++) begin
      bus.resp_rdy = give && n == rdly;
      bus.resp = r;
      @(negedge clk);
      if (bus.done != 0) begin
        lat = n; dv = bus.done; dr = bus.done_resp; dt = bus.done_tmo; dc = bus.clr_resp_rdy;
      end
      @(posedge clk); #1;
    end
    bus.resp_rdy = 1'b0;
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL done_wait: no done within 150 cycles at %0t", $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w, lat;
    logic [3:0] dv;
    logic [7:0] dr;
    logic dt, dc;
    int ord[6] = '{0, 1, 2, 3, 0, 3};
    bus.req = '0; bus.req_cmd = '0; bus.req_data = '0;
    bus.cmd_sent = 1'b0; bus.resp_rdy = 1'b0; bus.resp = '0;
    repeat (2) @(posedge clk); #1;
    rst = 1'b0;
    // single transaction, cmd/data must hold after the source changes
    bus.req_cmd[7:0] = 8'h05; bus.req_data[15:0] = 16'h1234; bus.req = 4'b0001;
    wait_gnt(w); chk("t1_who", w, 0);
    bus.req = '0; bus.req_cmd = '1; bus.req_data = '1;
    serve(2, 0, 1, 3, 8'hA5, lat, dv, dr, dt, dc);
    chk("t1_done", 32'(dv), 1); chk("t1_resp", 32'(dr), 'hA5);
    chk("t1_tmo", 32'(dt), 0); chk("t1_clr", 32'(dc), 1);
    @(negedge clk);
    chk("t1_cmd", 32'(bus.cmd), 'h05); chk("t1_data", 32'(bus.data), 'h1234);
    @(posedge clk); #1;
    // stale response while idle
    bus.resp_rdy = 1'b1; bus.resp = 8'h77;
    @(negedge clk);
    chk("t4_clr", 32'(bus.clr_resp_rdy), 1); chk("t4_done", 32'(bus.done), 0);
    @(posedge clk); #1;
    bus.resp_rdy = 1'b0; bus.req = 4'b0010;
    wait_gnt(w); chk("t4_who", w, 1);
    bus.req = '0;
    serve(0, 1, 1, 1, 8'h3C, lat, dv, dr, dt, dc);
    chk("t4_resp", 32'(dr), 'h3C); chk("t4_dv", 32'(dv), 2);
    // round robin order
    do_reset();
    bus.req = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      if (i == 4) bus.req = 4'b1001;
      wait_gnt(w); chk("t2_order", w, ord[i]);
      if (i == 5) bus.req = '0;
      serve(i % 3, 0, 1, 2 + i, 8'(8'h10 + i), lat, dv, dr, dt, dc);
    end
    // timeout
    bus.req = 4'b0100;
    wait_gnt(w); chk("t3_who", w, 2);
    bus.req = '0;
    serve(1, 0, 0, 0, 8'h00, lat, dv, dr, dt, dc);
    chk("t3_lat", lat, 100); chk("t3_done", 32'(dv), 4);
    chk("t3_tmo", 32'(dt), 1); chk("t3_resp", 32'(dr), 0);
    // response coinciding with the timeout cycle wins
    bus.req = 4'b1000;
    wait_gnt(w); chk("t5_who", w, 3);
    bus.req = '0;
    serve(0, 0, 1, 100, 8'h5A, lat, dv, dr, dt, dc);
    chk("t5_lat", lat, 100); chk("t5_tmo", 32'(dt), 0); chk("t5_resp", 32'(dr), 'h5A);
    // reset while waiting for the response
    bus.req = 4'b0001;
    wait_gnt(w); chk("t6_who", w, 0);
    bus.req = '0;
    @(negedge clk); @(posedge clk); #1;
    bus.cmd_sent = 1'b1;
    @(negedge clk); @(posedge clk); #1;
    bus.cmd_sent = 1'b0;
    repeat (3) begin @(negedge clk); @(posedge clk); #1; end
    do_reset();
    @(negedge clk);
    chk("t6_busy", 32'(bus.busy), 0); chk("t6_done", 32'(bus.done), 0);
    chk("t6_send", 32'(bus.send_cmd), 0); chk("t6_cmd", 32'(bus.cmd), 0);
    chk("t6_data", 32'(bus.data), 0);
    @(posedge clk); #1;
    bus.req = 4'b1001;
    wait_gnt(w); chk("t6_ptr", w, 0);
    bus.req = '0;
    serve(1, 0, 1, 4, 8'h99, lat, dv, dr, dt, dc);
    bus.req = 4'b0100;
    wait_gnt(w); chk("t6_who2", w, 2);
    bus.req = '0;
    serve(0, 0, 1, 2, 8'h42, lat, dv, dr, dt, dc);
    // random traffic
    for (int i = 0; i < 30; i++) begin
      bus.req_cmd = 32'($urandom);
      bus.req_data = {$urandom, $urandom};
      bus.req = 4'($urandom_range(1, 15));
      bus.resp_rdy = $urandom_range(0, 3) == 0;
      bus.resp = 8'($urandom);
      wait_gnt(w);
      bus.req = $urandom_range(0, 1) ? 4'($urandom) : 4'b0000;
      bus.req_cmd = 32'($urandom);
      serve($urandom_range(0, 4), 1'($urandom_range(0, 1)), $urandom_range(0, 7) != 0,
            $urandom_range(0, 9) == 0 ? 100 : $urandom_range(1, 20), 8'($urandom),
            lat, dv, dr, dt, dc);
    end
    bus.req = '0;
    repeat (3) begin @(negedge clk); @(posedge clk); #1; end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
